cv32e40p_fetch_req_ctrl: RTL and testbench

Fetch-side request controller. It sequences OBI instruction-memory transactions that fill the prefetch FIFO, which in turn feeds the instruction aligner. It tracks outstanding transactions and applies FIFO backpressure. On a branch it flushes the FIFO, redirects fetch to the word-aligned target, and discards stale in-flight responses so the aligner only ever sees post-branch words.

---
 rtl/cv32e40p_pkg.sv | 23 ++
 rtl/cv32e40p_fetch_req_ctrl.sv | 129 ++++++++++++
 tb/tb_cv32e40p_fetch_req_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cv32e40p_pkg
// Description : Shared types and constants for the fetch-side controllers.
//               Provides the fetch request controller state encoding and
//               the default prefetch FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_pkg;

    // Default prefetch FIFO depth in 32-bit words
    localparam int FETCH_FIFO_DEPTH = 4;

    // Fetch request controller states
    //   IDLE        : normal issue
    //   BRANCH_WAIT : redirect seen while a request was held ungranted
    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        BRANCH_WAIT = 1'b1
    } fetch_state_e;

endpackage : cv32e40p_pkg
`default_nettype wire

// File: rtl/cv32e40p_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fetch_req_ctrl
// Description : Fetch-side OBI request controller. Issues word fetches into
//               the prefetch FIFO, limits outstanding + buffered words to
//               DEPTH, and on a branch flushes the FIFO, redirects to the
//               word-aligned target and discards stale in-flight responses.
// Ports       : clk, rst_n          - clock, async active-low reset
//               req_i               - fetch enable from IF stage
//               branch_i            - one-cycle redirect strobe
//               branch_addr_i       - redirect target ([1:0] ignored)
//               fifo_cnt_i          - current FIFO occupancy
//               trans_valid_o/_addr_o, trans_ready_i - OBI request channel
//               resp_valid_i        - OBI response valid (in order)
//               fifo_push_o         - push response word into FIFO
//               fifo_flush_o        - clear FIFO
//               busy_o              - outstanding or request pending
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_fetch_req_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    output logic [31:0]      trans_addr_o,
    input  logic             resp_valid_i,
    output logic             fifo_push_o,
    output logic             fifo_flush_o,
    output logic             busy_o
);

    fetch_state_e     state_q;
    logic [31:0]      addr_q;
    logic [31:0]      baddr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    // A request was presented last cycle and not granted; it must be held
    logic             pend_q;

    logic [CNT_W:0]   occ;
    logic             credit;
    logic             accept;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt_nxt;
    logic             unused_baddr_lsb;

    // Halfword offset is resolved by the aligner, not here
    assign target           = {branch_addr_i[31:2], 2'b00};
    assign unused_baddr_lsb = ^branch_addr_i[1:0];

    // Sum at CNT_W+1 bits so DEPTH + DEPTH cannot wrap
    assign occ    = {1'b0, cnt_q} + {1'b0, fifo_cnt_i};
    assign credit = occ < (CNT_W+1)'(DEPTH);

    // A held request stays valid regardless of req_i/branch_i/credit;
    // trans_ready_i never feeds back into valid.
    assign trans_valid_o = pend_q || (req_i && !branch_i && credit);
    assign trans_addr_o  = addr_q;
    assign accept        = trans_valid_o && trans_ready_i;

    assign fifo_flush_o  = branch_i;
    assign fifo_push_o   = resp_valid_i && (flush_cnt_q == '0) && !branch_i;
    assign busy_o        = (cnt_q != '0) || trans_valid_o;

    assign cnt_nxt = cnt_q + CNT_W'(accept) - CNT_W'(resp_valid_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            baddr_q     <= '0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            pend_q <= trans_valid_o && !trans_ready_i;

            if (accept) begin
                addr_q <= addr_q + 32'd4;
            end

            // On a branch every transaction still outstanding after this
            // cycle (including one granted now) is stale. A request held
            // into BRANCH_WAIT is added when it is finally granted.
            if (branch_i) begin
                flush_cnt_q <= cnt_nxt;
            end else begin
                flush_cnt_q <= flush_cnt_q
                             - CNT_W'(resp_valid_i && (flush_cnt_q != '0))
                             + CNT_W'((state_q == BRANCH_WAIT) && accept);
            end

            case (state_q)
                IDLE: begin
                    if (branch_i) begin
                        if (pend_q && !trans_ready_i) begin
                            state_q <= BRANCH_WAIT;
                            baddr_q <= target;
                        end else begin
                            addr_q  <= target;
                        end
                    end
                end
                BRANCH_WAIT: begin
                    if (branch_i) begin
                        baddr_q <= target;
                    end
                    if (trans_ready_i) begin
                        addr_q  <= branch_i ? target : baddr_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : cv32e40p_fetch_req_ctrl
`default_nettype wire

// File: tb/tb_cv32e40p_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_fetch_req_ctrl
// Description : Self-checking bench for cv32e40p_fetch_req_ctrl. A queue of
//               in-flight transactions tagged stale/fresh, a held-request
//               record and a FIFO occupancy counter predict every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_fetch_req_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             req_i;
    logic             branch_i;
    logic [31:0]      branch_addr_i;
    logic [CNT_W-1:0] fifo_cnt_i;
    logic             trans_valid_o;
    logic             trans_ready_i;
    logic [31:0]      trans_addr_o;
    logic             resp_valid_i;
    logic             fifo_push_o;
    logic             fifo_flush_o;
    logic             busy_o;

    cv32e40p_fetch_req_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fifo_cnt_i    (fifo_cnt_i),
        .trans_valid_o (trans_valid_o),
        .trans_ready_i (trans_ready_i),
        .trans_addr_o  (trans_addr_o),
        .resp_valid_i  (resp_valid_i),
        .fifo_push_o   (fifo_push_o),
        .fifo_flush_o  (fifo_flush_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    bit          inflight[$];   // one entry per granted request: 1 = stale
    bit          held_valid;
    bit          held_stale;
    logic [31:0] held_addr;
    logic [31:0] issue_addr;
    int          fifo_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, compare, advance the reference.
    task automatic cycle(input bit req, input bit br, input logic [31:0] tgt,
                         input bit rdy, input bit rsp, input bit pop);
        bit          e_valid;
        bit          e_push;
        bit          e_busy;
        bit          acc;
        bit          do_resp;
        logic [31:0] e_addr;

        @(negedge clk);
        do_resp       = rsp && (inflight.size() > 0);
        req_i         = req;
        branch_i      = br;
        branch_addr_i = tgt;
        trans_ready_i = rdy;
        resp_valid_i  = do_resp;
        fifo_cnt_i    = CNT_W'(fifo_cnt);
        #1;

        if (held_valid) begin
            e_valid = 1'b1;
            e_addr  = held_addr;
        end else begin
            e_valid = req && !br && ((inflight.size() + fifo_cnt) < DEPTH);
            e_addr  = issue_addr;
        end
        e_push = do_resp && !inflight[0] && !br;
        e_busy = (inflight.size() != 0) || e_valid;

        check("valid", 32'(trans_valid_o), 32'(e_valid));
        if (e_valid) check("addr", trans_addr_o, e_addr);
        check("push",  32'(fifo_push_o),  32'(e_push));
        check("flush", 32'(fifo_flush_o), 32'(br));
        check("busy",  32'(busy_o),       32'(e_busy));

        acc = e_valid && rdy;
        if (do_resp) void'(inflight.pop_front());
        if (br) foreach (inflight[i]) inflight[i] = 1'b1;
        if (acc) inflight.push_back(held_valid ? (held_stale || br) : br);
        if (held_valid) begin
            if (rdy)     held_valid = 1'b0;
            else if (br) held_stale = 1'b1;
        end else if (e_valid) begin
            issue_addr = issue_addr + 32'd4;
            if (!rdy) begin
                held_valid = 1'b1;
                held_addr  = e_addr;
                held_stale = 1'b0;
            end
        end
        if (br) issue_addr = {tgt[31:2], 2'b00};
        if (br) fifo_cnt = 0;
        else    fifo_cnt = fifo_cnt + (e_push ? 1 : 0) - ((pop && fifo_cnt > 0) ? 1 : 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_i         = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        fifo_cnt_i    = '0;
        trans_ready_i = 1'b0;
        resp_valid_i  = 1'b0;
        held_valid    = 1'b0;
        held_stale    = 1'b0;
        held_addr     = '0;
        issue_addr    = '0;
        fifo_cnt      = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(trans_valid_o), 32'h0);
        check("rst_addr",  trans_addr_o,       32'h0);
        check("rst_push",  32'(fifo_push_o),   32'h0);
        check("rst_flush", 32'(fifo_flush_o),  32'h0);
        check("rst_busy",  32'(busy_o),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: one issue per cycle, pushes one cycle later
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Backpressure: no pops, FIFO fills and issue stops
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // Branch to 0x102 with two outstanding
        cycle(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h102, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // Branch to 0x200 while a request is held ungranted
        cycle(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // Branch coincident with the only response
        cycle(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // Address wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0,
                  $urandom,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cv32e40p_fetch_req_ctrl
`default_nettype wire
